// File: rtl/next_pc_predictor_if.sv
// Fetch-side bus of the next-PC predictor: current fetch PC, stall,
// the EXE resolution record, and the predicted next PC / flush back out.
interface next_pc_predictor_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pc_if;
  logic              stall;
  logic              resolve_valid;
  logic [DATA_W-1:0] resolve_pc;
  logic              resolve_is_branch;
  logic              resolve_is_jump;
  logic              resolve_taken;
  logic [DATA_W-1:0] resolve_target;
  logic              resolve_pred_taken;
  logic [DATA_W-1:0] resolve_pred_target;
  logic [DATA_W-1:0] pc_pred;
  logic              pred_taken;
  logic              flush;

  // Pipeline side: drives fetch PC and resolutions, consumes the prediction.
  modport master (
    output pc_if, stall, resolve_valid, resolve_pc, resolve_is_branch,
           resolve_is_jump, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_target,
    input  pc_pred, pred_taken, flush
  );

  // Predictor side.
  modport slave (
    input  pc_if, stall, resolve_valid, resolve_pc, resolve_is_branch,
           resolve_is_jump, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_target,
    output pc_pred, pred_taken, flush
  );
endinterface

// File: rtl/next_pc_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit counters, trained from
// EXE resolutions, with a redirect that is held across fetch stalls.
module next_pc_predictor #(
  parameter int DATA_W      = 32,
  parameter int BTB_ENTRIES = 16
) (
  input logic               clk,
  input logic               rst,
  next_pc_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_W - IDX_W - 2;

  typedef enum logic {IDLE, PEND} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       redirect_pc_q, redirect_pc_d;
  logic [BTB_ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]        tag_d    [BTB_ENTRIES];
  logic [DATA_W-1:0]       target_q [BTB_ENTRIES];
  logic [DATA_W-1:0]       target_d [BTB_ENTRIES];
  logic [1:0]              ctr_q    [BTB_ENTRIES];
  logic [1:0]              ctr_d    [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0]  jmp_q, jmp_d;

  logic [IDX_W-1:0]  fetch_idx, res_idx;
  logic [TAG_W-1:0]  fetch_tag, res_tag;
  logic              fetch_hit, btb_taken, res_hit;
  logic              res_active, mispredict;
  logic [DATA_W-1:0] correct_pc, fetch_seq_pc;

  // Combinational BTB lookup for the fetch PC and the resolving PC.
  always_comb begin
    fetch_idx    = bus.pc_if[IDX_W+1:2];
    fetch_tag    = bus.pc_if[DATA_W-1:IDX_W+2];
    fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    btb_taken    = fetch_hit && (jmp_q[fetch_idx] || ctr_q[fetch_idx][1]);
    fetch_seq_pc = bus.pc_if + DATA_W'(4);
    res_idx      = bus.resolve_pc[IDX_W+1:2];
    res_tag      = bus.resolve_pc[DATA_W-1:IDX_W+2];
    res_hit      = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  end

  // Resolution decode: only control-flow resolutions seen while IDLE count.
  always_comb begin
    res_active = !rst && (state_q == IDLE) && bus.resolve_valid &&
                 (bus.resolve_is_branch || bus.resolve_is_jump);
    mispredict = res_active &&
                 ((bus.resolve_taken != bus.resolve_pred_taken) ||
                  (bus.resolve_taken && (bus.resolve_target != bus.resolve_pred_target)));
    correct_pc = bus.resolve_taken ? bus.resolve_target
                                   : bus.resolve_pc + DATA_W'(4);
  end

  // BTB training: jumps always (re)write, branches update on hit or allocate when taken.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jmp_d    = jmp_q;
    if (res_active) begin
      if (bus.resolve_is_jump) begin
        valid_d[res_idx]  = 1'b1;
        tag_d[res_idx]    = res_tag;
        target_d[res_idx] = bus.resolve_target;
        ctr_d[res_idx]    = 2'b11;
        jmp_d[res_idx]    = 1'b1;
      end else if (res_hit) begin
        if (bus.resolve_taken) begin
          ctr_d[res_idx]    = (ctr_q[res_idx] == 2'b11) ? 2'b11 : ctr_q[res_idx] + 2'd1;
          target_d[res_idx] = bus.resolve_target;
        end else begin
          ctr_d[res_idx] = (ctr_q[res_idx] == 2'b00) ? 2'b00 : ctr_q[res_idx] - 2'd1;
        end
      end else if (bus.resolve_taken) begin
        valid_d[res_idx]  = 1'b1;
        tag_d[res_idx]    = res_tag;
        target_d[res_idx] = bus.resolve_target;
        ctr_d[res_idx]    = 2'b10;
        jmp_d[res_idx]    = 1'b0;
      end
    end
  end

  // Redirect FSM and next-PC selection; reset forces the plain sequential PC.
  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    bus.pc_pred    = fetch_seq_pc;
    bus.flush      = 1'b0;
    bus.pred_taken = !rst && btb_taken;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            bus.pc_pred = correct_pc;
            if (bus.stall) begin
              state_d       = PEND;
              redirect_pc_d = correct_pc;
            end else begin
              bus.flush = 1'b1;
            end
          end else if (btb_taken) begin
            bus.pc_pred = target_q[fetch_idx];
          end
        end
        PEND: begin
          bus.pc_pred = redirect_pc_q;
          if (!bus.stall) begin
            bus.flush = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and valid bits, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      valid_q       <= valid_d;
    end
  end

  // BTB payload storage; meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
    jmp_q    <= jmp_d;
  end
endmodule

// File: tb/tb_next_pc_predictor.sv
// Bench for next_pc_predictor: directed fetch/resolve vectors, a per-cycle
// reference model, and hand-computed spot checks.
module tb_next_pc_predictor;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  next_pc_predictor_if #(.DATA_W(32)) bus ();

  next_pc_predictor #(.DATA_W(32), .BTB_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: one record per BTB slot plus the held redirect.
  typedef struct {
    bit        v;
    bit [25:0] tag;
    bit [31:0] tgt;
    int        ctr;
    bit        jmp;
  } ent_t;

  ent_t      m_btb [16];
  bit        m_pend;
  bit [31:0] m_hold;
  bit        w_en;
  int        w_idx;
  ent_t      w_ent;
  bit        n_pend;
  bit [31:0] n_hold;
  bit        n_clear;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: derive the expected outputs from the rules, then stage the model update.
  always @(negedge clk) begin
    bit [31:0] exp_pc;
    bit        exp_pt;
    bit        exp_fl;
    int        idx;
    bit        hit;
    bit        ctrl;
    bit        mis;
    bit [31:0] corr;
    exp_pc  = bus.pc_if + 32'd4;
    exp_pt  = 1'b0;
    exp_fl  = 1'b0;
    w_en    = 1'b0;
    n_clear = rst;
    n_pend  = m_pend;
    n_hold  = m_hold;
    if (!rst) begin
      idx    = int'(bus.pc_if[5:2]);
      hit    = m_btb[idx].v && (m_btb[idx].tag == bus.pc_if[31:6]);
      exp_pt = hit && (m_btb[idx].jmp || m_btb[idx].ctr >= 2);
      if (m_pend) begin
        exp_pc = m_hold;
        exp_fl = !bus.stall;
        n_pend = bus.stall;
      end else begin
        ctrl = bus.resolve_valid && (bus.resolve_is_branch || bus.resolve_is_jump);
        mis  = ctrl && ((bus.resolve_taken != bus.resolve_pred_taken) ||
                        (bus.resolve_taken && bus.resolve_target != bus.resolve_pred_target));
        corr = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
        if (mis) begin
          exp_pc = corr;
          if (bus.stall) begin
            n_pend = 1'b1;
            n_hold = corr;
          end else begin
            exp_fl = 1'b1;
          end
        end else if (exp_pt) begin
          exp_pc = m_btb[idx].tgt;
        end
        if (ctrl) begin
          w_idx = int'(bus.resolve_pc[5:2]);
          w_ent = m_btb[w_idx];
          hit   = w_ent.v && (w_ent.tag == bus.resolve_pc[31:6]);
          if (bus.resolve_is_jump) begin
            w_en  = 1'b1;
            w_ent = '{1'b1, bus.resolve_pc[31:6], bus.resolve_target, 3, 1'b1};
          end else if (hit) begin
            w_en = 1'b1;
            if (bus.resolve_taken) begin
              w_ent.ctr = (w_ent.ctr < 3) ? w_ent.ctr + 1 : 3;
              w_ent.tgt = bus.resolve_target;
            end else begin
              w_ent.ctr = (w_ent.ctr > 0) ? w_ent.ctr - 1 : 0;
            end
          end else if (bus.resolve_taken) begin
            w_en  = 1'b1;
            w_ent = '{1'b1, bus.resolve_pc[31:6], bus.resolve_target, 2, 1'b0};
          end
        end
      end
    end
    checkOutput("model_pc_pred", bus.pc_pred, exp_pc);
    checkOutput("model_pred_taken", {31'd0, bus.pred_taken}, {31'd0, exp_pt});
    checkOutput("model_flush", {31'd0, bus.flush}, {31'd0, exp_fl});
  end

  // Commit the staged model update on the same edge the DUT updates.
  always @(posedge clk) begin
    if (n_clear) begin
      for (int i = 0; i < 16; i++) m_btb[i].v = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (w_en) m_btb[w_idx] = w_ent;
      m_pend = n_pend;
      m_hold = n_hold;
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic stall, input logic rv,
                               input logic [31:0] rpc, input logic br, input logic jp,
                               input logic tk, input logic [31:0] tgt,
                               input logic rpt, input logic [31:0] rptgt);
    bus.pc_if               = pc;
    bus.stall               = stall;
    bus.resolve_valid       = rv;
    bus.resolve_pc          = rpc;
    bus.resolve_is_branch   = br;
    bus.resolve_is_jump     = jp;
    bus.resolve_taken       = tk;
    bus.resolve_target      = tgt;
    bus.resolve_pred_taken  = rpt;
    bus.resolve_pred_target = rptgt;
  endtask

  task automatic fetchOnly(input logic [31:0] pc, input logic stall);
    applyStimulus(pc, stall, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Hand-computed spot check, taken mid-cycle after inputs settle.
  task automatic spot(input string name, input logic [31:0] exp_pc, input logic exp_pt, input logic exp_fl);
    #2;
    checkOutput({name, "_pc_pred"}, bus.pc_pred, exp_pc);
    checkOutput({name, "_pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_pt});
    checkOutput({name, "_flush"}, {31'd0, bus.flush}, {31'd0, exp_fl});
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    fetchOnly(32'h1000_0000, 1'b0);
    spot("during_reset", 32'h1000_0004, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    spot("after_reset", 32'h1000_0004, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(32'h1000_0020, 1'b0, 1'b1, 32'h1000_0010, 1'b1, 1'b0, 1'b1, 32'h1000_0100, 1'b0, 32'h0);
    spot("br_taken_mispred", 32'h1000_0100, 1'b0, 1'b1);
    stepCycle();
    fetchOnly(32'h1000_0010, 1'b0);
    spot("br_predicted", 32'h1000_0100, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(32'h1000_0104, 1'b0, 1'b1, 32'h1000_0010, 1'b1, 1'b0, 1'b0, 32'h1000_0100, 1'b1, 32'h1000_0100);
    spot("br_nt_first", 32'h1000_0014, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(32'h1000_0018, 1'b0, 1'b1, 32'h1000_0010, 1'b1, 1'b0, 1'b0, 32'h1000_0100, 1'b0, 32'h0);
    spot("br_nt_second", 32'h1000_001C, 1'b0, 1'b0);
    stepCycle();
    fetchOnly(32'h1000_0010, 1'b0);
    spot("br_now_nt", 32'h1000_0014, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(32'h1000_0034, 1'b1, 1'b1, 32'h1000_0030, 1'b1, 1'b0, 1'b1, 32'h1000_0200, 1'b0, 32'h0);
    spot("stall_c1", 32'h1000_0200, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(32'h1000_0034, 1'b1, 1'b1, 32'h1000_0050, 1'b0, 1'b1, 1'b1, 32'h1000_0300, 1'b0, 32'h0);
    spot("stall_c2", 32'h1000_0200, 1'b0, 1'b0);
    stepCycle();
    fetchOnly(32'h1000_0034, 1'b1);
    spot("stall_c3", 32'h1000_0200, 1'b0, 1'b0);
    stepCycle();
    fetchOnly(32'h1000_0034, 1'b0);
    spot("stall_release", 32'h1000_0200, 1'b0, 1'b1);
    stepCycle();
    fetchOnly(32'h1000_0200, 1'b0);
    spot("back_idle", 32'h1000_0204, 1'b0, 1'b0);
    stepCycle();
    fetchOnly(32'h1000_0050, 1'b0);
    spot("pend_resolve_ignored", 32'h1000_0054, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(32'h1000_0080, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b1, 1'b1, 32'h1000_0800, 1'b0, 32'h0);
    spot("jump_mispred", 32'h1000_0800, 1'b0, 1'b1);
    stepCycle();
    fetchOnly(32'h1000_0000, 1'b0);
    spot("jump_predicted", 32'h1000_0800, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(32'h1000_0000, 1'b0, 1'b1, 32'h1000_0040, 1'b0, 1'b1, 1'b1, 32'h1000_0900, 1'b1, 32'h1000_0900);
    spot("alias_same_cycle_old", 32'h1000_0800, 1'b1, 1'b0);
    stepCycle();
    fetchOnly(32'h1000_0000, 1'b0);
    spot("alias_miss", 32'h1000_0004, 1'b0, 1'b0);
    stepCycle();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h1000_0100, 1'b0, 1'b1, 32'h1000_0030, 1'b1, 1'b0, 1'b1, 32'h1000_0200, 1'b1, 32'h1000_0200);
      stepCycle();
    end
    applyStimulus(32'h1000_0100, 1'b0, 1'b1, 32'h1000_0030, 1'b1, 1'b0, 1'b0, 32'h1000_0200, 1'b1, 32'h1000_0200);
    spot("sat_nt_mispred", 32'h1000_0034, 1'b0, 1'b1);
    stepCycle();
    fetchOnly(32'h1000_0030, 1'b0);
    spot("sat_still_taken", 32'h1000_0200, 1'b1, 1'b0);
    stepCycle();

    fetchOnly(32'hFFFF_FFFC, 1'b0);
    spot("pc_wrap", 32'h0000_0000, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(32'h1000_0300, 1'b0, 1'b1, 32'h1000_0300, 1'b0, 1'b0, 1'b1, 32'h1000_0700, 1'b0, 32'h0);
    spot("non_control", 32'h1000_0304, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(32'h1000_0064, 1'b1, 1'b1, 32'h1000_0060, 1'b1, 1'b0, 1'b1, 32'h1000_0400, 1'b0, 32'h0);
    spot("pend_enter", 32'h1000_0400, 1'b0, 1'b0);
    stepCycle();
    rst = 1'b1;
    fetchOnly(32'h1000_0064, 1'b1);
    spot("reset_in_pend", 32'h1000_0068, 1'b0, 1'b0);
    stepCycle();
    rst = 1'b0;
    fetchOnly(32'h1000_0030, 1'b0);
    spot("post_reset_clear", 32'h1000_0034, 1'b0, 1'b0);
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
